// File: rtl/gfx256_pkg.sv
// Shared types for the gfx256 read-side memory arbiter and its round-robin picker.
package gfx256_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} rdarb_state_e;

  typedef logic [255:0] gfx_line_t;

  localparam int LINE_ADDR_LSB = 5;
  localparam int LINE_TAG_W    = 32 - LINE_ADDR_LSB;

endpackage

// File: rtl/gfx256_rr_pick.sv
// Combinational round-robin picker: first requester at or after (ptr+1) mod N.
// Zero latency; no state, so it applies no backpressure.
module gfx256_rr_pick #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any_req
);

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    grant   = ptr;
    any_req = |req;
    for (int i = N; i >= 1; i--) begin
      logic [PW-1:0] idx;
      idx = PW'((int'(ptr) + i) % N);
      if (req[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/gfx256_rdmem_arbiter.sv
// Round-robin share of the 256-bit wbm reader, one read outstanding; ack 3 cycles + reader latency.
// Backpressure: m_busy_i holds the grant in ISSUE. Optional line cache: GFX256_RDARB_LINECACHE_EN.
module gfx256_rdmem_arbiter
  import gfx256_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*32-1:0]   addr_i,
  input  logic [NREQ*32-1:0]   sel_i,
  output logic [NREQ-1:0]      ack_o,
  output gfx_line_t            data_o,
  output logic                 m_req_o,
  output logic [31:0]          m_addr_o,
  output logic [31:0]          m_sel_o,
  input  logic                 m_ack_i,
  input  gfx_line_t            m_data_i,
  input  logic                 m_busy_i,
  input  logic                 inv_i,
  output logic                 busy_o
);

  localparam int PW = $clog2(NREQ);

  rdarb_state_e  state, state_nxt;
  logic [PW-1:0] ptr, gidx, pick;
  logic          any_req;
  logic          hit;
  gfx_line_t     hit_line;
  logic [31:0]   addr_arr [NREQ];
  logic [31:0]   sel_arr  [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_slice
    assign addr_arr[k] = addr_i[32*k +: 32];
    assign sel_arr[k]  = sel_i[32*k +: 32];
  end

  gfx256_rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req     (req_i),
    .ptr     (ptr),
    .grant   (pick),
    .any_req (any_req)
  );

`ifdef GFX256_RDARB_LINECACHE_EN
  gfx_line_t             line_q;
  logic [LINE_TAG_W-1:0] tag_q;
  logic                  valid_q;
  logic                  inv_seen;

  assign hit      = valid_q && (tag_q == addr_arr[pick][31:LINE_ADDR_LSB]);
  assign hit_line = line_q;

  // An invalidate seen while the fetch is in flight may postdate the data, so the fill stays invalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q   <= '0;
      tag_q    <= '0;
      valid_q  <= 1'b0;
      inv_seen <= 1'b0;
    end else begin
      if (state == ISSUE || state == WAIT) inv_seen <= inv_seen | inv_i;
      else                                 inv_seen <= 1'b0;
      if (state == WAIT && m_ack_i) begin
        line_q  <= m_data_i;
        tag_q   <= m_addr_o[31:LINE_ADDR_LSB];
        valid_q <= !(inv_seen || inv_i);
      end else if (inv_i) begin
        valid_q <= 1'b0;
      end
    end
  end
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign hit        = 1'b0;
  assign hit_line   = '0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = hit ? ACK : ISSUE;
      ISSUE:   if (!m_busy_i) state_nxt = WAIT;
      WAIT:    if (m_ack_i) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      ptr      <= PW'(NREQ - 1);
      gidx     <= '0;
      m_req_o  <= 1'b0;
      m_addr_o <= '0;
      m_sel_o  <= '1;
      data_o   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_req) begin
          gidx     <= pick;
          ptr      <= pick;
          m_addr_o <= addr_arr[pick];
          m_sel_o  <= sel_arr[pick];
          if (hit) data_o <= hit_line;
        end
        ISSUE: if (!m_busy_i) m_req_o <= 1'b1;
        WAIT: if (m_ack_i) begin
          m_req_o <= 1'b0;
          data_o  <= m_data_i;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_o = '0;
    if (state == ACK) ack_o[gidx] = 1'b1;
  end

  assign busy_o = (state != IDLE);

endmodule
